// File: rtl/tz_pkg.sv
// Shared definitions for the clock's push-button front end: button indices and
// the per-channel debounce state encoding.
package tz_pkg;

  localparam int BTN_MODE  = 0;
  localparam int BTN_KOREA = 1;
  localparam int BTN_PARIS = 2;
  localparam int BTN_NY    = 3;
  localparam int BTN_UK    = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_e;

  // A button counts as "down" once accepted, until the release is accepted.
  function automatic logic is_down_state(input btn_state_e s);
    return (s == HELD) || (s == REL_WAIT);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, press pulse and level.
// Optional long-press pulse is built only when BTN_LONGPRESS_EN is defined.
module btn_debounce_ch
  import tz_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int LONG_CYCLES     = 50000000,
  parameter int LP_W            = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_pulse,
  output logic o_lvl,
  output logic o_lp_pulse
);

  if (DEBOUNCE_CYCLES < 2 || (2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt_w
    $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end
  if (LONG_CYCLES < 1 || (2 ** LP_W) <= LONG_CYCLES) begin : g_bad_lp_w
    $error("btn_debounce_ch: LONG_CYCLES must be >= 1 and fit in LP_W bits");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_lvl;
  logic             w_db_done;
  logic             w_to_idle;

  assign w_db_done = (r_cnt == DB_LAST);
  assign w_to_idle = (r_state == REL_WAIT) && !r_sync2 && w_db_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The counter restarts on every state change, so each wait state measures
  // an unbroken run of stable synced samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_lvl   <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_sync2) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!r_sync2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_db_done) begin
            r_state <= HELD;
            r_cnt   <= '0;
            r_pulse <= 1'b1;
            r_lvl   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!r_sync2) begin
            r_state <= REL_WAIT;
            r_cnt   <= '0;
          end
        end
        REL_WAIT: begin
          if (r_sync2) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (w_db_done) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_lvl   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_pulse = r_pulse;
  assign o_lvl   = r_lvl;

`ifdef BTN_LONGPRESS_EN
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES);
  localparam logic [LP_W-1:0] LP_PRE  = LP_W'(LONG_CYCLES - 1);

  logic [LP_W-1:0] r_lp_cnt;
  logic            r_lp_pulse;

  // Saturating at LONG_CYCLES limits the pulse to once per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lp_cnt   <= '0;
      r_lp_pulse <= 1'b0;
    end else begin
      r_lp_pulse <= 1'b0;
      if (w_to_idle) begin
        r_lp_cnt <= '0;
      end else if (is_down_state(r_state) && (r_lp_cnt != LP_LAST)) begin
        r_lp_cnt <= r_lp_cnt + LP_W'(1);
        if (r_lp_cnt == LP_PRE) begin
          r_lp_pulse <= 1'b1;
        end
      end
    end
  end

  assign o_lp_pulse = r_lp_pulse;
`else
  assign o_lp_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: N_BTN independent debounce channels.
// Define BTN_LONGPRESS_EN to enable the per-channel long-press pulse.
module btn_pulse_gen
  import tz_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int LONG_CYCLES     = 50000000,
  parameter int LP_W            = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_p,
  output logic [N_BTN-1:0] btn_lvl,
  output logic [N_BTN-1:0] btn_lp_p
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .LONG_CYCLES     (LONG_CYCLES),
      .LP_W            (LP_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_raw      (btn_raw[gi]),
      .o_pulse    (btn_p[gi]),
      .o_lvl      (btn_lvl[gi]),
      .o_lp_pulse (btn_lp_p[gi])
    );
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen with short debounce/long-press settings.
// Expected output events are queued by the stimulus and matched by a monitor.
module tb_btn_pulse_gen;
  import tz_pkg::*;

  localparam int NB = 5;
  localparam int DB = 4;
  localparam int LC = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_p;
  logic [NB-1:0] btn_lvl;
  logic [NB-1:0] btn_lp_p;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int            cyc;
    logic [NB-1:0] p;
    logic [NB-1:0] lvl;
    logic [NB-1:0] lp;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           mon_e;
  logic [NB-1:0] prev_lvl = '0;

  btn_pulse_gen #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (4),
    .LONG_CYCLES     (LC),
    .LP_W            (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_p    (btn_p),
    .btn_lvl  (btn_lvl),
    .btn_lp_p (btn_lp_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Any pulse or level change is an output event; it must match the queue head.
  always @(negedge clk) begin
    if (btn_p != '0 || btn_lp_p != '0 || btn_lvl != prev_lvl) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d p=%b lvl=%b lp=%b required no event",
                 cyc, btn_p, btn_lvl, btn_lp_p);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.p !== btn_p || mon_e.lvl !== btn_lvl || mon_e.lp !== btn_lp_p) begin
          errors++;
          $display("FAIL event got cyc=%0d p=%b lvl=%b lp=%b required cyc=%0d p=%b lvl=%b lp=%b",
                   cyc, btn_p, btn_lvl, btn_lp_p, mon_e.cyc, mon_e.p, mon_e.lvl, mon_e.lp);
        end
      end
    end
    prev_lvl = btn_lvl;
  end

  function automatic logic [NB-1:0] onehot(input int i);
    return NB'(1) << i;
  endfunction

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic push(input int c, input logic [NB-1:0] p, input logic [NB-1:0] lvl,
                      input logic [NB-1:0] lp);
    ev_t e;
    e.cyc = c;
    e.p   = p;
    e.lvl = lvl;
    e.lp  = lp;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%b required=%b", nm, act, req);
    end
  endtask

  initial begin
    int e0;
    int e4;
    int r;
    logic [NB-1:0] m;

    #1 rst = 1'b1;
    steps(3);
    #1;
    chk("reset_btn_p", btn_p, '0);
    chk("reset_btn_lvl", btn_lvl, '0);
    chk("reset_btn_lp_p", btn_lp_p, '0);
    rst = 1'b0;
    steps(3);

    // 1: clean press on KOREA held 20 cycles
    m = onehot(BTN_KOREA);
    step();
    e0 = cyc + 1;
    btn_raw[BTN_KOREA] = 1'b1;
    push(e0 + 6, m, m, '0);
`ifdef BTN_LONGPRESS_EN
    push(e0 + 22, '0, m, m);
`endif
    push(e0 + 26, '0, '0, '0);
    steps(20);
    btn_raw[BTN_KOREA] = 1'b0;
    steps(12);

    // 2: press bounce on NY
    m = onehot(BTN_NY);
    step();
    e0 = cyc + 1;
    btn_raw[BTN_NY] = 1'b1;
    steps(3);
    btn_raw[BTN_NY] = 1'b0;
    steps(2);
    btn_raw[BTN_NY] = 1'b1;
    r = cyc + 1;
    push(r + 6, m, m, '0);
    push(r + 16, '0, '0, '0);
    steps(10);
    btn_raw[BTN_NY] = 1'b0;
    steps(12);

    // 3: release bounce on UK, then clean release
    m = onehot(BTN_UK);
    step();
    e0 = cyc + 1;
    btn_raw[BTN_UK] = 1'b1;
    push(e0 + 6, m, m, '0);
    push(e0 + 19, '0, '0, '0);
    steps(8);
    btn_raw[BTN_UK] = 1'b0;
    steps(2);
    btn_raw[BTN_UK] = 1'b1;
    steps(3);
    btn_raw[BTN_UK] = 1'b0;
    steps(12);

    // 4: simultaneous MODE and PARIS
    m = onehot(BTN_MODE) | onehot(BTN_PARIS);
    step();
    e0 = cyc + 1;
    btn_raw = m;
    push(e0 + 6, m, m, '0);
    push(e0 + 14, '0, '0, '0);
    steps(8);
    btn_raw = '0;
    steps(12);

    // 5: reset during a KOREA debounce while UK is held
    step();
    e4 = cyc + 1;
    btn_raw[BTN_UK] = 1'b1;
    push(e4 + 6, onehot(BTN_UK), onehot(BTN_UK), '0);
    steps(8);
    btn_raw[BTN_KOREA] = 1'b1;
    steps(4);
    rst = 1'b1;
    btn_raw[BTN_UK] = 1'b0;
    push(cyc + 1, '0, '0, '0);
    #1;
    chk("midreset_btn_p", btn_p, '0);
    chk("midreset_btn_lvl", btn_lvl, '0);
    chk("midreset_btn_lp_p", btn_lp_p, '0);
    steps(3);
    rst = 1'b0;
    r = cyc + 1;
    m = onehot(BTN_KOREA);
    push(r + 6, m, m, '0);
    push(r + 14, '0, '0, '0);
    steps(8);
    btn_raw[BTN_KOREA] = 1'b0;
    steps(12);

    // 6: long press on PARIS held 30 cycles
    m = onehot(BTN_PARIS);
    step();
    e0 = cyc + 1;
    btn_raw[BTN_PARIS] = 1'b1;
    push(e0 + 6, m, m, '0);
`ifdef BTN_LONGPRESS_EN
    push(e0 + 22, '0, m, m);
`endif
    push(e0 + 36, '0, '0, '0);
    steps(30);
    btn_raw[BTN_PARIS] = 1'b0;
    steps(12);

    steps(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
